flick_debouncer: RTL and testbench

Upstream conditioning stage for the bound-flasher FSM. It takes the raw, asynchronous, bouncy push-button input and drives the clean, synchronous `flick` level that the flasher samples at its kick-back points. It also produces single-cycle rise/fall strobes, a bouncing indicator and a press counter for debug LEDs.

---
 rtl/flick_debouncer_pkg.sv | 15 +
 rtl/flick_debouncer_if.sv | 37 +++
 rtl/bit_synchronizer.sv | 32 +++
 rtl/flick_debouncer.sv | 124 ++++++++++++
 tb/tb_flick_debouncer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/flick_debouncer_pkg.sv
// flick_debouncer_pkg: shared definitions for the flick input conditioning stage.
//   - FSM state encodings of the debouncer (legacy two-bit constants).
//   - Default qualification length: 1 ms at a 50 MHz system clock.
package flick_debouncer_pkg;

    // Encoding keeps bit 1 equal to the accepted level, so S_HI/S_HI2LO both
    // read as "currently pressed".
    localparam logic [1:0] S_LO    = 2'b00;
    localparam logic [1:0] S_LO2HI = 2'b01;
    localparam logic [1:0] S_HI    = 2'b11;
    localparam logic [1:0] S_HI2LO = 2'b10;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/flick_debouncer_if.sv
// flick_debouncer_if: signal bundle between the raw button, the debouncer and
// its consumers (bound-flasher FSM, debug LEDs).
//   btn_in      raw button level, asynchronous to clk
//   flick       debounced level, 1 = pressed
//   flick_rise  one-cycle strobe on an accepted press
//   flick_fall  one-cycle strobe on an accepted release
//   bouncing    1 while a level change is being qualified
//   press_count accepted presses, 8-bit wrapping
// Modports: master = debouncer side, slave = button source / consumer side.
interface flick_debouncer_if;

    logic       btn_in;
    logic       flick;
    logic       flick_rise;
    logic       flick_fall;
    logic       bouncing;
    logic [7:0] press_count;

    modport master (
        input  btn_in,
        output flick,
        output flick_rise,
        output flick_fall,
        output bouncing,
        output press_count
    );

    modport slave (
        output btn_in,
        input  flick,
        input  flick_rise,
        input  flick_fall,
        input  bouncing,
        input  press_count
    );

endinterface

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous bit.
//   clk    destination clock
//   rst    asynchronous, active-low reset; all flops load RESET_VAL
//   d      asynchronous input
//   q      synchronized output, STAGES clk edges after d
// RESET_VAL should equal the idle level of d so that reset release does not
// look like an input transition downstream.
module bit_synchronizer #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop of
    // the chain samples the value its predecessor held before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/flick_debouncer.sv
// flick_debouncer: turns the raw, bouncy push button into the clean
// synchronous flick level sampled by the bound-flasher FSM.
//   clk    system clock, shared with the flasher
//   rst    asynchronous, active-low reset
//   bus    flick_debouncer_if.master: btn_in in; flick, flick_rise,
//          flick_fall, bouncing, press_count out (all registered)
// A level change is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized samples of the new level; any opposite sample restarts
// qualification from scratch.
module flick_debouncer
    import flick_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    flick_debouncer_if.master  bus
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    logic             s;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             flick_nxt, rise_nxt, fall_nxt;
    logic [7:0]       count_nxt;

    // Synchronizer idles at the released raw level, so reset release never
    // presents a fake press to the FSM.
    bit_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (btn_sync)
    );

    assign s = BTN_ACTIVE_LOW ? ~btn_sync : btn_sync;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flick_nxt = bus.flick;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        count_nxt = bus.press_count;
        case (state)
            S_LO: begin
                if (s) begin
                    state_nxt = S_LO2HI;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_LO2HI: begin
                if (!s) begin
                    state_nxt = S_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HI;
                    cnt_nxt   = '0;
                    flick_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                    count_nxt = bus.press_count + 8'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HI: begin
                if (!s) begin
                    state_nxt = S_HI2LO;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_HI2LO: begin
                if (s) begin
                    state_nxt = S_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LO;
                    cnt_nxt   = '0;
                    flick_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_LO;
            cnt             <= '0;
            bus.flick       <= 1'b0;
            bus.flick_rise  <= 1'b0;
            bus.flick_fall  <= 1'b0;
            bus.bouncing    <= 1'b0;
            bus.press_count <= 8'd0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            bus.flick       <= flick_nxt;
            bus.flick_rise  <= rise_nxt;
            bus.flick_fall  <= fall_nxt;
            // Registered copy of "next state is a qualifying state".
            bus.bouncing    <= (state_nxt == S_LO2HI) || (state_nxt == S_HI2LO);
            bus.press_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_flick_debouncer.sv
// tb_flick_debouncer: directed, table-driven bench for flick_debouncer with
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2 (dut_a, active-high button) and a second
// instance with BTN_ACTIVE_LOW=1 (dut_b).
module tb_flick_debouncer;

    typedef struct packed {
        logic       btn;
        logic       flick;
        logic       rise;
        logic       fall;
        logic       bouncing;
        logic [7:0] count;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t tbl[$];

    flick_debouncer_if bus_a ();
    flick_debouncer_if bus_b ();

    flick_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .BTN_ACTIVE_LOW  (1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    flick_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge with inputs already driven: one active edge, then
    // back to the following negedge for sampling.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic add(input logic b, input logic f, input logic r, input logic fa,
                       input logic bo, input logic [7:0] c);
        vec_t v;
        v.btn = b; v.flick = f; v.rise = r; v.fall = fa; v.bouncing = bo; v.count = c;
        tbl.push_back(v);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Expected outputs after the edge at which each btn value is applied.
        // Clean press (rise 5 edges after the first 1-vector).
        add(0,0,0,0,0,0); add(0,0,0,0,0,0);
        add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,0,0,1,0);
        add(1,0,0,0,1,0); add(1,0,0,0,1,0); add(1,1,1,0,0,1);
        add(1,1,0,0,0,1); add(1,1,0,0,0,1); add(1,1,0,0,0,1); add(1,1,0,0,0,1);
        // Release with a 2-cycle high blip restarting the count.
        add(0,1,0,0,0,1); add(0,1,0,0,0,1); add(1,1,0,0,1,1); add(1,1,0,0,1,1);
        add(0,1,0,0,0,1); add(0,1,0,0,0,1); add(0,1,0,0,1,1); add(0,1,0,0,1,1);
        add(0,1,0,0,1,1); add(0,0,0,1,0,1); add(0,0,0,0,0,1); add(0,0,0,0,0,1);
        // Glitch of 3 samples: rejected.
        add(1,0,0,0,0,1); add(1,0,0,0,0,1); add(1,0,0,0,1,1); add(0,0,0,0,1,1);
        add(0,0,0,0,1,1); add(0,0,0,0,0,1); add(0,0,0,0,0,1);
        // Bouncy press 1,0,1,0,1 then held.
        add(1,0,0,0,0,1); add(0,0,0,0,0,1); add(1,0,0,0,1,1); add(0,0,0,0,0,1);
        add(1,0,0,0,1,1); add(1,0,0,0,0,1); add(1,0,0,0,1,1); add(1,0,0,0,1,1);
        add(1,0,0,0,1,1); add(1,1,1,0,0,2); add(1,1,0,0,0,2); add(1,1,0,0,0,2);

        // Reset state.
        rst = 1'b0;
        bus_a.btn_in = 1'b0;
        bus_b.btn_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset flick",    {7'd0, bus_a.flick},      8'd0);
        check("reset rise",     {7'd0, bus_a.flick_rise}, 8'd0);
        check("reset fall",     {7'd0, bus_a.flick_fall}, 8'd0);
        check("reset bouncing", {7'd0, bus_a.bouncing},   8'd0);
        check("reset count",    bus_a.press_count,        8'd0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            bus_a.btn_in = tbl[i].btn;
            step(1);
            check($sformatf("vec%0d flick", i),    {7'd0, bus_a.flick},      {7'd0, tbl[i].flick});
            check($sformatf("vec%0d rise", i),     {7'd0, bus_a.flick_rise}, {7'd0, tbl[i].rise});
            check($sformatf("vec%0d fall", i),     {7'd0, bus_a.flick_fall}, {7'd0, tbl[i].fall});
            check($sformatf("vec%0d bouncing", i), {7'd0, bus_a.bouncing},   {7'd0, tbl[i].bouncing});
            check($sformatf("vec%0d count", i),    bus_a.press_count,        tbl[i].count);
        end

        // Active-low instance idled released the whole time.
        check("b idle flick", {7'd0, bus_b.flick},       8'd0);
        check("b idle count", bus_b.press_count,         8'd0);

        // Reset in the middle of qualification (S_LO2HI, cnt=2).
        bus_a.btn_in = 1'b0;
        step(10);
        check("pre-reset flick", {7'd0, bus_a.flick}, 8'd0);
        bus_a.btn_in = 1'b1;
        step(4);
        check("pre-reset bouncing", {7'd0, bus_a.bouncing}, 8'd1);
        rst = 1'b0;
        #1;
        check("async reset bouncing", {7'd0, bus_a.bouncing}, 8'd0);
        check("async reset flick",    {7'd0, bus_a.flick},    8'd0);
        check("async reset count",    bus_a.press_count,      8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(5);
        check("post-reset flick@5", {7'd0, bus_a.flick}, 8'd0);
        step(1);
        check("post-reset flick@6", {7'd0, bus_a.flick},      8'd1);
        check("post-reset rise@6",  {7'd0, bus_a.flick_rise}, 8'd1);
        check("post-reset count",   bus_a.press_count,        8'd1);

        // Active-low button: idle 1 through reset, no strobe on release.
        bus_a.btn_in = 1'b0;
        bus_b.btn_in = 1'b1;
        rst = 1'b0;
        #1;
        check("b reset flick", {7'd0, bus_b.flick}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check($sformatf("b release rise%0d", k),  {7'd0, bus_b.flick_rise}, 8'd0);
            check($sformatf("b release flick%0d", k), {7'd0, bus_b.flick},      8'd0);
            check($sformatf("b release bounce%0d", k), {7'd0, bus_b.bouncing},  8'd0);
        end
        bus_b.btn_in = 1'b0;
        step(5);
        check("b press flick@5", {7'd0, bus_b.flick}, 8'd0);
        step(1);
        check("b press flick@6", {7'd0, bus_b.flick},      8'd1);
        check("b press rise@6",  {7'd0, bus_b.flick_rise}, 8'd1);
        check("b press count",   bus_b.press_count,        8'd1);
        step(2);

        // 255 further presses: 1 + 255 wraps the 8-bit counter to 0.
        for (int p = 0; p < 255; p++) begin
            bus_b.btn_in = 1'b1;
            step(8);
            bus_b.btn_in = 1'b0;
            step(8);
            if (p == 253) check("b count 255", bus_b.press_count, 8'd255);
        end
        check("b count wrap", bus_b.press_count, 8'd0);
        check("b wrap flick", {7'd0, bus_b.flick}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
